turn_manager: RTL and testbench

// - Turn sequencer for the two-tank game; produces the player1flag/player2flag enables that both tank movement blocks consume.
// - Grants one player an aim/move window and issues the fire request on SPACE.
// - Freezes both tanks during bullet flight and applies hit damage.
// - Hands the turn to the other player, or declares game over.
// - Sits between the keyboard keycode source and tank/bullet blocks; clocked by frame_clk (one step per video frame).

---
 rtl/tank_game_pkg.sv | 9 +
 rtl/key_edge_detect.sv | 17 +
 rtl/turn_manager.sv | 112 +++++++++++
 tb/tb_turn_manager.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_game_pkg.sv
// tank_game_pkg: shared state, key and winner encodings for the tank game turn logic.
package tank_game_pkg;
  typedef enum logic [2:0] {IDLE, P1_AIM, P2_AIM, FLIGHT, SETTLE, OVER} turn_state_t;
  typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_T1 = 2'b01, WIN_T2 = 2'b10, WIN_DRAW = 2'b11} winner_t;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_START = 8'h28;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: one-frame press pulses for SPACE and START from the raw keycode.
module key_edge_detect
  import tank_game_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       space_pe,
  output logic       start_pe
);
  logic [7:0] prev;
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) prev <= 8'h00;
    else prev <= keycode;
  assign space_pe = keycode == KEY_SPACE && prev != KEY_SPACE;
  assign start_pe = keycode == KEY_START && prev != KEY_START;
endmodule

// File: rtl/turn_manager.sv
// turn_manager: two-tank turn sequencer (aim, fire, flight, settle, game over).
// Optional aim-window timeout is enabled by defining TURN_TIMER_EN.
module turn_manager
  import tank_game_pkg::*;
#(
  parameter int MAX_HP = 3,
  parameter int SETTLE_FRAMES = 30,
  parameter int FLIGHT_MAX = 255,
  parameter int TURN_FRAMES = 240
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       bullet_done,
  input  logic       hit_tank1,
  input  logic       hit_tank2,
  output logic       player1flag,
  output logic       player2flag,
  output logic       fire_req,
  output logic       shooter,
  output logic [2:0] hp1,
  output logic [2:0] hp2,
  output logic [7:0] turn_timer,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_P1 = P1_AIM;
  localparam logic [2:0] ST_P2 = P2_AIM;
  localparam logic [2:0] ST_FLIGHT = FLIGHT;
  localparam logic [2:0] ST_SETTLE = SETTLE;
  localparam logic [2:0] ST_OVER = OVER;
  logic [2:0] state, n1, n2;
  logic [7:0] cnt;
  logic space_pe, start_pe, last_p2, in_aim, settle_done, going_aim, timeout;
  key_edge_detect u_keys (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .keycode(keycode),
    .space_pe(space_pe),
    .start_pe(start_pe)
  );
  assign player1flag = state == ST_P1;
  assign player2flag = state == ST_P2;
  assign game_over = state == ST_OVER;
  assign in_aim = player1flag || player2flag;
  assign settle_done = state == ST_SETTLE && cnt == 8'(SETTLE_FRAMES - 1);
  assign going_aim = ((state == ST_IDLE || state == ST_OVER) && start_pe) || settle_done;
  assign n1 = hp1 - 3'(hit_tank1 && hp1 != 3'd0);
  assign n2 = hp2 - 3'(hit_tank2 && hp2 != 3'd0);
`ifdef TURN_TIMER_EN
  logic [7:0] tt;
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) tt <= 8'd0;
    else tt <= going_aim ? 8'(TURN_FRAMES) : (in_aim && !space_pe && tt != 8'd0) ? tt - 8'd1 : 8'd0;
  assign turn_timer = tt;
  assign timeout = tt == 8'd0;
`else
  assign turn_timer = 8'd0;
  assign timeout = 1'b0;
`endif
  // cnt is shared by flight and settle; it restarts from 0 on every state change
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= ST_IDLE;
      cnt <= 8'd0;
      fire_req <= 1'b0;
      shooter <= 1'b0;
      last_p2 <= 1'b0;
      hp1 <= 3'(MAX_HP);
      hp2 <= 3'(MAX_HP);
      winner <= WIN_NONE;
    end else begin
      fire_req <= 1'b0;
      cnt <= going_aim ? 8'd0 : cnt + 8'd1;
      case (state)
        ST_IDLE: if (start_pe) state <= ST_P1;
        ST_P1, ST_P2:
          if (space_pe) begin
            state <= ST_FLIGHT;
            fire_req <= 1'b1;
            shooter <= state == ST_P2;
            last_p2 <= state == ST_P2;
            cnt <= 8'd0;
          end else if (timeout) begin
            state <= ST_SETTLE;
            last_p2 <= state == ST_P2;
            cnt <= 8'd0;
          end
        ST_FLIGHT:
          if (bullet_done) begin
            hp1 <= n1;
            hp2 <= n2;
            cnt <= 8'd0;
            state <= (n1 == 3'd0 || n2 == 3'd0) ? ST_OVER : ST_SETTLE;
            winner <= (n1 == 3'd0 && n2 == 3'd0) ? WIN_DRAW : n1 == 3'd0 ? WIN_T2 : n2 == 3'd0 ? WIN_T1 : WIN_NONE;
          end else if (cnt == 8'(FLIGHT_MAX)) begin
            state <= ST_SETTLE;
            cnt <= 8'd0;
          end
        ST_SETTLE: if (settle_done) state <= last_p2 ? ST_P1 : ST_P2;
        ST_OVER:
          if (start_pe) begin
            hp1 <= 3'(MAX_HP);
            hp2 <= 3'(MAX_HP);
            winner <= WIN_NONE;
            state <= ST_P1;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_turn_manager.sv
// tb_turn_manager: scenario bench for turn_manager; fire_req events are scoreboarded against expected shooters.
module tb_turn_manager;
  logic frame_clk = 1'b0;
  logic Reset_n;
  logic [7:0] keycode;
  logic bullet_done, hit_tank1, hit_tank2;
  logic player1flag, player2flag, fire_req, shooter, game_over;
  logic [2:0] hp1, hp2;
  logic [7:0] turn_timer;
  logic [1:0] winner;
  int checks = 0, errors = 0;
  logic exp_fire[$];
  localparam logic [7:0] K_SPACE = 8'h2C, K_START = 8'h28;

  turn_manager #(.TURN_FRAMES(4)) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .bullet_done(bullet_done), .hit_tank1(hit_tank1), .hit_tank2(hit_tank2),
    .player1flag(player1flag), .player2flag(player2flag), .fire_req(fire_req),
    .shooter(shooter), .hp1(hp1), .hp2(hp2), .turn_timer(turn_timer),
    .game_over(game_over), .winner(winner)
  );

  always #5 frame_clk = ~frame_clk;

  // every fire_req frame must match a shot the bench has announced
  always @(negedge frame_clk) if (fire_req) begin
    checks++;
    if (exp_fire.size() == 0) begin
      errors++;
      $display("FAIL unexpected_fire_req got shooter %0d want no fire", shooter);
    end else begin
      logic s;
      s = exp_fire.pop_front();
      if (shooter !== s) begin
        errors++;
        $display("FAIL fire_shooter got %0d want %0d", shooter, s);
      end
    end
  end

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({player1flag, player2flag, fire_req, shooter, game_over} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {player1flag, player2flag, fire_req, shooter, game_over});
    end
    checks++;
    if ({hp1, hp2, turn_timer, winner} !== {3'd3, 3'd3, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_vals got hp %0d/%0d tt %0d win %0d want 3/3 0 0", hp1, hp2, turn_timer, winner);
    end
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    keycode = K_START;
    step();
    checks++;
    if ({player1flag, player2flag, hp1, hp2} !== {2'b10, 3'd3, 3'd3}) begin
      errors++;
      $display("FAIL start_p1 got f %b%b hp %0d/%0d want 10 3/3", player1flag, player2flag, hp1, hp2);
    end
    keycode = 8'h00;
    step();
  endtask

  task automatic test_fire_hold();
    keycode = K_SPACE;
    exp_fire.push_back(1'b0);
    step();
    checks++;
    if ({fire_req, shooter, player1flag, player2flag} !== 4'b1000) begin
      errors++;
      $display("FAIL fire_first got %b want 1000", {fire_req, shooter, player1flag, player2flag});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fire_req !== 1'b0) begin
        errors++;
        $display("FAIL fire_held frame %0d got %0d want 0", i, fire_req);
      end
    end
  endtask

  task automatic test_hit_and_settle();
    bullet_done = 1'b1;
    hit_tank2 = 1'b1;
    step();
    bullet_done = 1'b0;
    hit_tank2 = 1'b0;
    checks++;
    if ({hp1, hp2} !== {3'd3, 3'd2}) begin
      errors++;
      $display("FAIL hit_tank2 got %0d/%0d want 3/2", hp1, hp2);
    end
    repeat (29) step();
    checks++;
    if (player2flag !== 1'b0) begin
      errors++;
      $display("FAIL settle_early got %0d want 0", player2flag);
    end
    step();
    checks++;
    if ({player1flag, player2flag} !== 2'b01) begin
      errors++;
      $display("FAIL settle_p2 got %b%b want 01", player1flag, player2flag);
    end
    repeat (3) step();
    checks++;
    if ({fire_req, player2flag} !== 2'b01) begin
      errors++;
      $display("FAIL held_space_refire got %b want 01", {fire_req, player2flag});
    end
    keycode = 8'h00;
    bullet_done = 1'b1;
    hit_tank1 = 1'b1;
    step();
    bullet_done = 1'b0;
    hit_tank1 = 1'b0;
    checks++;
    if ({hp1, player2flag} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL stray_bullet_done got hp1 %0d p2 %0d want 3 1", hp1, player2flag);
    end
  endtask

  task automatic test_miss();
    int n;
    keycode = K_SPACE;
    exp_fire.push_back(1'b1);
    step();
    keycode = 8'h00;
    checks++;
    if ({fire_req, shooter} !== 2'b11) begin
      errors++;
      $display("FAIL p2_fire got %b want 11", {fire_req, shooter});
    end
    n = 0;
    while (!player1flag && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n !== 256 + 30) begin
      errors++;
      $display("FAIL miss_timing got %0d frames want %0d", n, 256 + 30);
    end
    checks++;
    if ({hp1, hp2, game_over} !== {3'd3, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL miss_hp got %0d/%0d go %0d want 3/2 0", hp1, hp2, game_over);
    end
  endtask

  task automatic shoot(input logic s, input logic h1, input logic h2, input logic [2:0] e1, input logic [2:0] e2, input logic over);
    keycode = K_SPACE;
    exp_fire.push_back(s);
    step();
    keycode = 8'h00;
    step();
    bullet_done = 1'b1;
    hit_tank1 = h1;
    hit_tank2 = h2;
    step();
    bullet_done = 1'b0;
    hit_tank1 = 1'b0;
    hit_tank2 = 1'b0;
    checks++;
    if ({hp1, hp2, game_over} !== {e1, e2, over}) begin
      errors++;
      $display("FAIL shot_result got %0d/%0d go %0d want %0d/%0d %0d", hp1, hp2, game_over, e1, e2, over);
    end
    if (!over) begin
      repeat (30) step();
      checks++;
      if ({player1flag, player2flag} !== {s, ~s}) begin
        errors++;
        $display("FAIL turn_handover got %b%b want %b%b", player1flag, player2flag, s, ~s);
      end
    end
  endtask

  task automatic test_game_over();
    shoot(1'b0, 1'b1, 1'b1, 3'd2, 3'd1, 1'b0);
    shoot(1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0);
    shoot(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1);
    checks++;
    if ({winner, player1flag, player2flag} !== 4'b1100) begin
      errors++;
      $display("FAIL draw_winner got %b want 1100", {winner, player1flag, player2flag});
    end
    keycode = K_START;
    step();
    keycode = 8'h00;
    checks++;
    if ({hp1, hp2, winner, game_over, player1flag} !== {3'd3, 3'd3, 2'b00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL restart got hp %0d/%0d win %0d go %0d p1 %0d want 3/3 0 0 1", hp1, hp2, winner, game_over, player1flag);
    end
  endtask

  task automatic test_reset_mid_flight();
    shoot(1'b0, 1'b0, 1'b1, 3'd3, 3'd2, 1'b0);
    keycode = K_SPACE;
    exp_fire.push_back(1'b1);
    step();
    keycode = 8'h00;
    repeat (3) step();
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({player1flag, player2flag, fire_req, shooter, game_over, hp1, hp2, winner} !== {5'b0, 3'd3, 3'd3, 2'b00}) begin
      errors++;
      $display("FAIL async_reset got f %b%b fr %0d sh %0d hp %0d/%0d", player1flag, player2flag, fire_req, shooter, hp1, hp2);
    end
    step();
    Reset_n = 1'b1;
    repeat (5) step();
    checks++;
    if ({player1flag, player2flag, fire_req} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 000", {player1flag, player2flag, fire_req});
    end
  endtask

`ifdef TURN_TIMER_EN
  task automatic test_turn_timer();
    keycode = K_START;
    step();
    keycode = 8'h00;
    for (int i = 4; i >= 0; i--) begin
      checks++;
      if ({turn_timer, player1flag} !== {8'(i), 1'b1}) begin
        errors++;
        $display("FAIL turn_timer got %0d p1 %0d want %0d 1", turn_timer, player1flag, i);
      end
      step();
    end
    checks++;
    if ({player1flag, player2flag, fire_req} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_settle got %b want 000", {player1flag, player2flag, fire_req});
    end
    repeat (30) step();
    checks++;
    if ({player2flag, turn_timer} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL timeout_handover got p2 %0d tt %0d want 1 4", player2flag, turn_timer);
    end
  endtask
`endif

  initial begin
    keycode = 8'h00;
    bullet_done = 1'b0;
    hit_tank1 = 1'b0;
    hit_tank2 = 1'b0;
    test_reset();
    test_start();
    test_fire_hold();
    test_hit_and_settle();
    test_miss();
    test_game_over();
    test_reset_mid_flight();
`ifdef TURN_TIMER_EN
    test_turn_timer();
`endif
    repeat (2) step();
    checks++;
    if (exp_fire.size() != 0) begin
      errors++;
      $display("FAIL missing_fire_req got %0d pending want 0", exp_fire.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
